// File: rtl/apb_i2c_regfile.sv
// APB slave register file sitting between the APB bus and the I2C master core.
// Holds CTRL / PRESCALE / SADDR, a small TX staging queue, START/STOP command
// pulses, RX pop-on-read and a STATUS readback. Reads take one wait state.
// Optional feature: define APB_I2C_IRQ_EN to enable the IRQ_MASK register and irq.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | no transfer in flight, waiting for an APB setup phase
// ST_RWAIT | read wait state: read mux captured into PRDATA, PREADY low
// ST_DONE  | access phase completes (PREADY high while PSEL & PENABLE)

module apb_i2c_regfile #(
    parameter int                DATA_W       = 8,
    parameter int                ADDR_W       = 4,
    parameter int                TXQ_DEPTH    = 4,
    parameter logic [DATA_W-1:0] PRESCALE_RST = DATA_W'(8'h04)
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [ADDR_W-1:0] PADDR,
    input  logic [DATA_W-1:0] PWDATA,
    output logic [DATA_W-1:0] PRDATA,
    output logic              PREADY,
    output logic              PSLVERR,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_valid,
    output logic              rx_pop,
    input  logic [7:0]        core_status,
    output logic              ctrl_en,
    output logic              ctrl_rw,
    output logic              cmd_start,
    output logic              cmd_stop,
    output logic [6:0]        slave_addr,
    output logic [DATA_W-1:0] prescale,
    output logic              irq
);

    localparam int             PTR_W        = $clog2(TXQ_DEPTH);
    localparam logic [PTR_W:0] TXQ_FULL_CNT = (PTR_W+1)'(TXQ_DEPTH);

    localparam logic [2:0] A_CTRL     = 3'd0;
    localparam logic [2:0] A_CMD      = 3'd1;
    localparam logic [2:0] A_PRESCALE = 3'd2;
    localparam logic [2:0] A_SADDR    = 3'd3;
    localparam logic [2:0] A_TXDATA   = 3'd4;
    localparam logic [2:0] A_RXDATA   = 3'd5;
    localparam logic [2:0] A_STATUS   = 3'd6;
    localparam logic [2:0] A_IRQMASK  = 3'd7;

    typedef enum logic [1:0] {ST_IDLE, ST_RWAIT, ST_DONE} state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] prdata_q, prdata_d;
    logic              rd_err_q, rd_err_d;
    logic              rx_pop_q, rx_pop_d;
    logic              cmd_start_q, cmd_start_d;
    logic              cmd_stop_q, cmd_stop_d;
    logic [1:0]        ctrl_q, ctrl_d;
    logic [DATA_W-1:0] prescale_q, prescale_d;
    logic [6:0]        saddr_q, saddr_d;
    logic [DATA_W-1:0] txq_mem_q [TXQ_DEPTH];
    logic [DATA_W-1:0] txq_mem_d [TXQ_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]    count_q, count_d;

    logic              access, wr_acc, rd_acc, unmapped;
    logic [2:0]        reg_idx;
    logic              txq_empty, txq_full;
    logic              wr_err, rd_err_now;
    logic              txq_push, txq_pop, txq_flush;
    logic [DATA_W-1:0] rd_mux, status_word, irq_mask_rd;
    logic              unused_bits;

    assign unmapped    = |(PADDR >> 3);
    assign reg_idx     = PADDR[2:0];
    assign access      = (state_q == ST_DONE) && PSEL && PENABLE;
    assign wr_acc      = access && PWRITE;
    assign rd_acc      = access && !PWRITE;
    assign txq_empty   = (count_q == '0);
    assign txq_full    = (count_q == TXQ_FULL_CNT);
    assign status_word = DATA_W'({core_status[7:5], 2'b00, txq_full, txq_empty, rx_valid});
    assign unused_bits = ^core_status[4:0];

    // Full is judged on the registered count, i.e. before any same-cycle pop.
    assign wr_err     = unmapped || ((reg_idx == A_TXDATA) && txq_full);
    assign rd_err_now = unmapped || ((reg_idx == A_RXDATA) && !rx_valid);

    assign txq_push  = wr_acc && !unmapped && (reg_idx == A_TXDATA) && !txq_full;
    assign txq_pop   = !txq_empty && tx_ready;
    assign txq_flush = wr_acc && !unmapped && (reg_idx == A_CMD) && PWDATA[2];

    assign PRDATA     = prdata_q;
    assign PREADY     = access;
    assign PSLVERR    = access && (PWRITE ? wr_err : rd_err_q);
    assign tx_data    = txq_mem_q[rd_ptr_q];
    assign tx_valid   = !txq_empty;
    assign rx_pop     = rx_pop_q;
    assign ctrl_en    = ctrl_q[0];
    assign ctrl_rw    = ctrl_q[1];
    assign cmd_start  = cmd_start_q;
    assign cmd_stop   = cmd_stop_q;
    assign slave_addr = saddr_q;
    assign prescale   = prescale_q;

    // Read data mux, sampled into PRDATA during the wait state.
    always_comb begin
        rd_mux = '0;
        if (!unmapped) begin
            case (reg_idx)
                A_CTRL:     rd_mux = DATA_W'(ctrl_q);
                A_PRESCALE: rd_mux = prescale_q;
                A_SADDR:    rd_mux = DATA_W'(saddr_q);
                A_RXDATA:   rd_mux = rx_valid ? rx_data : '0;
                A_STATUS:   rd_mux = status_word;
                A_IRQMASK:  rd_mux = irq_mask_rd;
                default:    rd_mux = '0;
            endcase
        end
    end

    // APB transfer FSM: next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (PSEL && !PENABLE) state_d = PWRITE ? ST_DONE : ST_RWAIT;
            end
            ST_RWAIT: state_d = PSEL ? ST_DONE : ST_IDLE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Register writes, command pulses, read capture and TX queue bookkeeping.
    always_comb begin
        prdata_d    = prdata_q;
        rd_err_d    = rd_err_q;
        ctrl_d      = ctrl_q;
        prescale_d  = prescale_q;
        saddr_d     = saddr_q;
        txq_mem_d   = txq_mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        rx_pop_d    = rd_acc && !unmapped && (reg_idx == A_RXDATA) && !rd_err_q;
        cmd_start_d = wr_acc && !unmapped && (reg_idx == A_CMD) && PWDATA[0];
        cmd_stop_d  = wr_acc && !unmapped && (reg_idx == A_CMD) && PWDATA[1];

        if (state_q == ST_RWAIT && PSEL) begin
            prdata_d = rd_mux;
            rd_err_d = rd_err_now;
        end

        if (wr_acc && !unmapped) begin
            case (reg_idx)
                A_CTRL:     ctrl_d     = PWDATA[1:0];
                A_PRESCALE: prescale_d = PWDATA;
                A_SADDR:    saddr_d    = PWDATA[6:0];
                default:    ;
            endcase
        end

        // Flush overrides any push or pop landing in the same cycle.
        if (txq_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (txq_push) begin
                txq_mem_d[wr_ptr_q] = PWDATA;
                wr_ptr_d            = wr_ptr_q + PTR_W'(1);
            end
            if (txq_pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (txq_push && !txq_pop) count_d = count_q + (PTR_W+1)'(1);
            if (!txq_push && txq_pop) count_d = count_q - (PTR_W+1)'(1);
        end
    end

    // State and register flops, synchronous reset.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q     <= ST_IDLE;
            prdata_q    <= '0;
            rd_err_q    <= 1'b0;
            rx_pop_q    <= 1'b0;
            cmd_start_q <= 1'b0;
            cmd_stop_q  <= 1'b0;
            ctrl_q      <= '0;
            prescale_q  <= PRESCALE_RST;
            saddr_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            for (int i = 0; i < TXQ_DEPTH; i++) txq_mem_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            prdata_q    <= prdata_d;
            rd_err_q    <= rd_err_d;
            rx_pop_q    <= rx_pop_d;
            cmd_start_q <= cmd_start_d;
            cmd_stop_q  <= cmd_stop_d;
            ctrl_q      <= ctrl_d;
            prescale_q  <= prescale_d;
            saddr_q     <= saddr_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            txq_mem_q   <= txq_mem_d;
        end
    end

`ifdef APB_I2C_IRQ_EN
    // Mask bit 2 gates arb_lost so all three interrupt sources are maskable.
    logic [2:0] irq_mask_q, irq_mask_d;
    logic       irq_q, irq_d;

    assign irq_mask_rd = DATA_W'(irq_mask_q);
    assign irq         = irq_q;

    // Interrupt mask write and registered level interrupt.
    always_comb begin
        irq_mask_d = irq_mask_q;
        if (wr_acc && !unmapped && (reg_idx == A_IRQMASK)) irq_mask_d = PWDATA[2:0];
        irq_d = (irq_mask_q[0] && rx_valid) ||
                (irq_mask_q[1] && txq_empty) ||
                (irq_mask_q[2] && core_status[6]);
    end

    // Interrupt flops.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            irq_mask_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            irq_mask_q <= irq_mask_d;
            irq_q      <= irq_d;
        end
    end
`else
    assign irq_mask_rd = '0;
    assign irq         = 1'b0;
`endif

endmodule

// File: tb/tb_apb_i2c_regfile.sv
`timescale 1ns/1ps
module tb_apb_i2c_regfile;

    localparam int DATA_W    = 8;
    localparam int ADDR_W    = 4;
    localparam int TXQ_DEPTH = 4;

    logic              PCLK = 1'b0;
    logic              PRESET, PSEL, PENABLE, PWRITE;
    logic [ADDR_W-1:0] PADDR;
    logic [DATA_W-1:0] PWDATA, PRDATA;
    logic              PREADY, PSLVERR;
    logic [DATA_W-1:0] tx_data, rx_data, prescale;
    logic              tx_valid, tx_ready, rx_valid, rx_pop;
    logic [7:0]        core_status;
    logic              ctrl_en, ctrl_rw, cmd_start, cmd_stop, irq;
    logic [6:0]        slave_addr;

    apb_i2c_regfile #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .TXQ_DEPTH(TXQ_DEPTH), .PRESCALE_RST(8'h04)
    ) dut (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_pop(rx_pop),
        .core_status(core_status), .ctrl_en(ctrl_en), .ctrl_rw(ctrl_rw),
        .cmd_start(cmd_start), .cmd_stop(cmd_stop), .slave_addr(slave_addr),
        .prescale(prescale), .irq(irq)
    );

    always #5 PCLK = ~PCLK;

    typedef struct packed {
        logic       wr;
        logic [3:0] addr;
        logic [7:0] wdata;
        logic [7:0] rdata;
        logic       err;
    } vec_t;

    vec_t       vecs[$];
    logic [7:0] exp_q[$];
    int         n_cmp = 0;
    int         n_err = 0;
    int         rx_pop_cnt = 0;
    int         start_cnt = 0;
    int         stop_cnt = 0;
    logic [7:0] rd;
    logic       er;
    int         w;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One APB transfer; optionally holds tx_ready high for the first access cycle.
    task automatic apb_xfer(input logic wr_i, input logic [3:0] addr_i, input logic [7:0] wdata_i,
                            input logic pulse_ready, output logic [7:0] rdata_o,
                            output logic err_o, output int waits_o);
        @(negedge PCLK);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr_i; PADDR = addr_i; PWDATA = wdata_i;
        @(negedge PCLK);
        PENABLE = 1'b1;
        if (pulse_ready) tx_ready = 1'b1;
        waits_o = 0;
        #1;
        while (PREADY !== 1'b1 && waits_o < 8) begin
            @(negedge PCLK);
            #1;
            waits_o++;
        end
        check("pready seen", PREADY, 1);
        rdata_o = PRDATA;
        err_o   = PSLVERR;
        @(negedge PCLK);
        PSEL = 1'b0; PENABLE = 1'b0;
        if (pulse_ready) tx_ready = 1'b0;
    endtask

    // TXDATA push; the scoreboard decides whether the queue must reject it.
    task automatic tx_push(input logic [7:0] d, input logic pulse_ready);
        logic exp_err;
        logic [7:0] r;
        logic e;
        int ws;
        exp_err = (exp_q.size() >= TXQ_DEPTH);
        if (!exp_err) exp_q.push_back(d);
        apb_xfer(1'b1, 4'd4, d, pulse_ready, r, e, ws);
        check($sformatf("txdata 0x%0h pslverr", d), e, exp_err);
    endtask

    task automatic tx_drain();
        @(negedge PCLK);
        tx_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge PCLK);
            #1;
            if (tx_valid !== 1'b1) break;
        end
        tx_ready = 1'b0;
        check("tx drained", tx_valid, 0);
        check("scoreboard empty", exp_q.size(), 0);
    endtask

    // Pulse counters and TX scoreboard consumer.
    always @(negedge PCLK) begin
        logic [7:0] e;
        #2;
        if (rx_pop === 1'b1) rx_pop_cnt++;
        if (cmd_start === 1'b1) start_cnt++;
        if (cmd_stop === 1'b1) stop_cnt++;
        if (tx_valid === 1'b1 && tx_ready === 1'b1 && PRESET === 1'b0) begin
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
            check("tx pop data", tx_data, e);
        end
    end

    initial begin
        PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0; PWDATA = '0;
        tx_ready = 1'b0; rx_data = '0; rx_valid = 1'b0; core_status = '0;
        repeat (3) @(negedge PCLK);
        PRESET = 1'b0;
        #1;
        check("rst PREADY", PREADY, 0);
        check("rst PSLVERR", PSLVERR, 0);
        check("rst PRDATA", PRDATA, 0);
        check("rst tx_valid", tx_valid, 0);
        check("rst rx_pop", rx_pop, 0);
        check("rst ctrl", {ctrl_rw, ctrl_en}, 0);
        check("rst cmd", {cmd_stop, cmd_start}, 0);
        check("rst slave_addr", slave_addr, 0);
        check("rst prescale", prescale, 8'h04);
        check("rst irq", irq, 0);

        //                wr    addr   wdata  rdata  err
        vecs.push_back('{1'b0, 4'd2,  8'h00, 8'h04, 1'b0});
        vecs.push_back('{1'b0, 4'd0,  8'h00, 8'h00, 1'b0});
        vecs.push_back('{1'b0, 4'd3,  8'h00, 8'h00, 1'b0});
        vecs.push_back('{1'b0, 4'd6,  8'h00, 8'h02, 1'b0});
        vecs.push_back('{1'b1, 4'd0,  8'h02, 8'h00, 1'b0});
        vecs.push_back('{1'b0, 4'd0,  8'h00, 8'h02, 1'b0});
        vecs.push_back('{1'b1, 4'd2,  8'hC8, 8'h00, 1'b0});
        vecs.push_back('{1'b0, 4'd2,  8'h00, 8'hC8, 1'b0});
        vecs.push_back('{1'b1, 4'd3,  8'h5A, 8'h00, 1'b0});
        vecs.push_back('{1'b0, 4'd3,  8'h00, 8'h5A, 1'b0});
        vecs.push_back('{1'b0, 4'd1,  8'h00, 8'h00, 1'b0});
        vecs.push_back('{1'b0, 4'd5,  8'h00, 8'h00, 1'b1});
        vecs.push_back('{1'b0, 4'd9,  8'h00, 8'h00, 1'b1});
        vecs.push_back('{1'b1, 4'd12, 8'hFF, 8'h00, 1'b1});
        vecs.push_back('{1'b1, 4'd6,  8'hFF, 8'h00, 1'b0});
        vecs.push_back('{1'b0, 4'd6,  8'h00, 8'h02, 1'b0});
        vecs.push_back('{1'b1, 4'd7,  8'h01, 8'h00, 1'b0});
`ifdef APB_I2C_IRQ_EN
        vecs.push_back('{1'b0, 4'd7,  8'h00, 8'h01, 1'b0});
`else
        vecs.push_back('{1'b0, 4'd7,  8'h00, 8'h00, 1'b0});
`endif
        foreach (vecs[i]) begin
            apb_xfer(vecs[i].wr, vecs[i].addr, vecs[i].wdata, 1'b0, rd, er, w);
            check($sformatf("vec%0d pslverr", i), er, vecs[i].err);
            check($sformatf("vec%0d waits", i), w, vecs[i].wr ? 0 : 1);
            if (!vecs[i].wr) check($sformatf("vec%0d prdata", i), rd, vecs[i].rdata);
        end
        #1;
        check("ctrl_en", ctrl_en, 0);
        check("ctrl_rw", ctrl_rw, 1);
        check("prescale out", prescale, 8'hC8);
        check("slave_addr out", slave_addr, 7'h5A);
        check("no rx_pop on error read", rx_pop_cnt, 0);

        // START / STOP pulses
        apb_xfer(1'b1, 4'd1, 8'h01, 1'b0, rd, er, w);
        #1;
        check("cmd_start high", cmd_start, 1);
        check("cmd_stop quiet", cmd_stop, 0);
        @(negedge PCLK); #1;
        check("cmd_start low", cmd_start, 0);
        check("cmd_start count", start_cnt, 1);
        apb_xfer(1'b1, 4'd1, 8'h02, 1'b0, rd, er, w);
        #1;
        check("cmd_stop high", cmd_stop, 1);
        @(negedge PCLK); #1;
        check("cmd_stop low", cmd_stop, 0);
        check("cmd_stop count", stop_cnt, 1);

        // TX queue overflow, then drain in order
        for (int d = 8'h11; d <= 8'h15; d++) tx_push(8'(d), 1'b0);
        #1;
        check("txq head", tx_data, 8'h11);
        apb_xfer(1'b0, 4'd6, 8'h00, 1'b0, rd, er, w);
        check("status full", rd, 8'h04);
        tx_drain();

        // RX read with data present
        rx_valid = 1'b1; rx_data = 8'hA5; core_status = 8'hE0;
        apb_xfer(1'b0, 4'd6, 8'h00, 1'b0, rd, er, w);
        check("status rx/core", rd, 8'hE3);
        core_status = 8'h00;
        apb_xfer(1'b0, 4'd5, 8'h00, 1'b0, rd, er, w);
        check("rxdata prdata", rd, 8'hA5);
        check("rxdata pslverr", er, 0);
        check("rxdata waits", w, 1);
        #1;
        check("rx_pop high", rx_pop, 1);
        rx_valid = 1'b0;
        @(negedge PCLK); #1;
        check("rx_pop low", rx_pop, 0);
        check("rx_pop count", rx_pop_cnt, 1);

        // Full queue: same-cycle pop does not make room for the write
        for (int d = 8'h21; d <= 8'h24; d++) tx_push(8'(d), 1'b0);
        tx_push(8'h25, 1'b1);
        #1;
        check("head after pop", tx_data, 8'h22);
        apb_xfer(1'b0, 4'd6, 8'h00, 1'b0, rd, er, w);
        check("status count 3", rd, 8'h00);
        apb_xfer(1'b1, 4'd1, 8'h04, 1'b0, rd, er, w);
        check("flush pslverr", er, 0);
        exp_q.delete();
        #1;
        check("flush tx_valid", tx_valid, 0);

        // Push and pop in the same cycle on a non-full queue
        tx_push(8'h77, 1'b0);
        #1;
        check("post-flush head", tx_data, 8'h77);
        tx_push(8'h78, 1'b1);
        #1;
        check("push+pop valid", tx_valid, 1);
        check("push+pop head", tx_data, 8'h78);
        tx_drain();

        // PSEL dropped after setup: no side effect, FSM recovers
        @(negedge PCLK);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 4'd0; PWDATA = 8'h01;
        @(negedge PCLK);
        PSEL = 1'b0;
        @(negedge PCLK);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 4'd2;
        @(negedge PCLK);
        PSEL = 1'b0;
        #1;
        check("aborted write ctrl_en", ctrl_en, 0);
        apb_xfer(1'b0, 4'd0, 8'h00, 1'b0, rd, er, w);
        check("ctrl after abort", rd, 8'h02);
        check("waits after abort", w, 1);

        // Reset in the middle of a transfer
        tx_push(8'h33, 1'b0);
        @(negedge PCLK);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 4'd4; PWDATA = 8'h44;
        PRESET = 1'b1;
        @(negedge PCLK);
        PENABLE = 1'b1;
        @(negedge PCLK);
        PSEL = 1'b0; PENABLE = 1'b0; PRESET = 1'b0;
        exp_q.delete();
        #1;
        check("mid-rst tx_valid", tx_valid, 0);
        check("mid-rst PREADY", PREADY, 0);
        check("mid-rst prescale", prescale, 8'h04);
        check("mid-rst slave_addr", slave_addr, 0);
        apb_xfer(1'b0, 4'd2, 8'h00, 1'b0, rd, er, w);
        check("post-rst prescale rd", rd, 8'h04);

        // Interrupt
        apb_xfer(1'b1, 4'd7, 8'h01, 1'b0, rd, er, w);
        check("irqmask wr pslverr", er, 0);
        #1;
        check("irq before rx", irq, 0);
        @(negedge PCLK);
        rx_valid = 1'b1;
        #1;
        check("irq same cycle", irq, 0);
        @(negedge PCLK); #1;
`ifdef APB_I2C_IRQ_EN
        check("irq after rx", irq, 1);
`else
        check("irq tied low", irq, 0);
`endif
        rx_valid = 1'b0;
        repeat (2) @(negedge PCLK);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
